// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and indexing helper for the 3x3 matrix
// result buffer.
package matrix_pkg;

  localparam int DATA_W    = 16;
  localparam int N_ENTRIES = 9;
  localparam int ADDR_W    = 4;
  localparam int ROW_LEN   = 3;

  localparam logic [N_ENTRIES-1:0] FULL_MASK = {N_ENTRIES{1'b1}};
  localparam logic [ADDR_W-1:0]    LAST_IDX  = ADDR_W'(N_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] elem_idx(input int row, input int col);
    return ADDR_W'(row * ROW_LEN + col);
  endfunction

endpackage

// File: rtl/result_regfile.sv
// Nine-entry result storage: two registered write ports (port 1 wins on an
// address collision) and one combinational read port.
module result_regfile
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [N_ENTRIES];

  // Element storage with port-1 priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (wr1_en && (wr1_addr == ADDR_W'(i))) begin
          mem_q[i] <= wr1_data;
        end else if (wr2_en && (wr2_addr == ADDR_W'(i))) begin
          mem_q[i] <= wr2_data;
        end
      end
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      rd_data = (rd_addr == ADDR_W'(i)) ? mem_q[i] : rd_data;
    end
  end

endmodule

// File: rtl/matrix_result_buffer.sv
// Collects the nine product elements in any order from two MAC ports, then
// streams them row-major over valid/ready and pulses done.
module matrix_result_buffer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              done,
  output logic              err
);

  state_e                 state_q, state_d;
  logic [N_ENTRIES-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   wr_window_s;
  logic                   addr1_ok_s, addr2_ok_s, same_addr_s;
  logic                   acc1_s, acc2_s, err_evt_s, hs_s;
  logic [N_ENTRIES-1:0]   wr_bits_s, mask_new_s;
  logic [ADDR_W-1:0]      rd_addr_s;
  logic [DATA_W-1:0]      rd_data_s, fwd_data_s;

  assign wr_window_s = (state_q == IDLE) || (state_q == COLLECT);
  assign addr1_ok_s  = (wr1_addr < ADDR_W'(N_ENTRIES));
  assign addr2_ok_s  = (wr2_addr < ADDR_W'(N_ENTRIES));
  assign same_addr_s = wr1_en && wr2_en && (wr1_addr == wr2_addr);
  assign acc1_s      = wr_window_s && !clear && wr1_en && addr1_ok_s;
  assign acc2_s      = wr_window_s && !clear && wr2_en && addr2_ok_s && !same_addr_s;
  assign err_evt_s   = (wr1_en && !addr1_ok_s) || (wr2_en && !addr2_ok_s) || same_addr_s ||
                       (!wr_window_s && (wr1_en || wr2_en));
  assign hs_s        = valid_q && dout_ready;

  // Read address runs one ahead on a handshake so the next element is registered in time.
  assign rd_addr_s = ((state_q == STREAM) && hs_s && (ptr_q != LAST_IDX)) ?
                     (ptr_q + ADDR_W'(1)) : ptr_q;

  // Element 0 may be written in the very cycle the mask completes.
  assign fwd_data_s = (acc1_s && (wr1_addr == ADDR_W'(0))) ? wr1_data :
                      (acc2_s && (wr2_addr == ADDR_W'(0))) ? wr2_data : rd_data_s;

  result_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr1_en   (acc1_s),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .wr2_en   (acc2_s),
    .wr2_addr (wr2_addr),
    .wr2_data (wr2_data),
    .rd_addr  (rd_addr_s),
    .rd_data  (rd_data_s)
  );

  // Fill-mask bits set by this cycle's accepted writes.
  always_comb begin
    wr_bits_s = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      wr_bits_s[i] = (acc1_s && (wr1_addr == ADDR_W'(i))) ||
                     (acc2_s && (wr2_addr == ADDR_W'(i)));
    end
    mask_new_s = mask_q | wr_bits_s;
  end

  // Next-state and output-register logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q | err_evt_s;

    if (clear) begin
      state_d = IDLE;
      mask_d  = '0;
      ptr_d   = '0;
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mask_d = mask_new_s;
          if (|wr_bits_s) begin
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
        COLLECT: begin
          mask_d = mask_new_s;
          if (mask_new_s == FULL_MASK) begin
            state_d = STREAM;
            ptr_d   = '0;
            valid_d = 1'b1;
            data_d  = fwd_data_s;
            last_d  = 1'b0;
          end else begin
            state_d = COLLECT;
          end
        end
        STREAM: begin
          if (hs_s && (ptr_q == LAST_IDX)) begin
            state_d = DONE;
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else if (hs_s) begin
            ptr_d  = ptr_q + ADDR_W'(1);
            data_d = rd_data_s;
            last_d = (ptr_q == (LAST_IDX - ADDR_W'(1)));
          end else begin
            state_d = STREAM;
          end
        end
        DONE: begin
          state_d = IDLE;
          mask_d  = '0;
          ptr_d   = '0;
        end
        default: begin
          state_d = IDLE;
          mask_d  = '0;
          ptr_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dout_valid = valid_q;
  assign dout_data  = data_q;
  assign dout_last  = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matrix_result_buffer.sv
// Directed self-checking bench for matrix_result_buffer.
module tb_matrix_result_buffer;
  import matrix_pkg::*;

  logic              clk, reset, clear;
  logic              wr1_en, wr2_en, dout_ready;
  logic [ADDR_W-1:0] wr1_addr, wr2_addr;
  logic [DATA_W-1:0] wr1_data, wr2_data;
  logic              dout_valid, dout_last, done, err;
  logic [DATA_W-1:0] dout_data;

  int checks = 0;
  int errors = 0;

  matrix_result_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .wr2_en     (wr2_en),
    .wr2_addr   (wr2_addr),
    .wr2_data   (wr2_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_last  (dout_last),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq(input logic [DATA_W-1:0] base);
    for (int i = 0; i < N_ENTRIES; i++) begin
      wr1_en   = 1'b1;
      wr1_addr = ADDR_W'(i);
      wr1_data = base + DATA_W'(i);
      tick();
    end
    wr1_en = 1'b0;
  endtask

  // Expects element k = base+k (or ovr_val at ovr_idx), nine back-to-back.
  task automatic stream_check(input string name, input logic [DATA_W-1:0] base,
                              input int ovr_idx, input logic [DATA_W-1:0] ovr_val);
    logic [DATA_W-1:0] exp;
    dout_ready = 1'b1;
    for (int k = 0; k < N_ENTRIES; k++) begin
      exp = (k == ovr_idx) ? ovr_val : (base + DATA_W'(k));
      check($sformatf("%s_valid%0d", name, k), {31'd0, dout_valid}, 32'd1);
      check($sformatf("%s_data%0d", name, k), {16'd0, dout_data}, {16'd0, exp});
      check($sformatf("%s_last%0d", name, k), {31'd0, dout_last}, (k == 8) ? 32'd1 : 32'd0);
      tick();
    end
    check($sformatf("%s_done", name), {31'd0, done}, 32'd1);
    check($sformatf("%s_valid_after", name), {31'd0, dout_valid}, 32'd0);
    tick();
    check($sformatf("%s_done_pulse", name), {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic pat [4];
    int   k, hs, cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b0; clear = 1'b0; dout_ready = 1'b0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0;
    #2;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_data", {16'd0, dout_data}, 32'd0);
    check("rst_last", {31'd0, dout_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // In-order fill through port 1.
    dout_ready = 1'b1;
    fill_seq(16'h0010);
    stream_check("inorder", 16'h0010, 15, 16'h0000);
    check("inorder_err", {31'd0, err}, 32'd0);

    // Interleaved, descending: wr1 even, wr2 odd; element 0 is the final write.
    dout_ready = 1'b0;
    for (int p = 4; p >= 1; p--) begin
      wr1_en = 1'b1; wr1_addr = ADDR_W'(2 * p);     wr1_data = 16'h0200 + DATA_W'(2 * p);
      wr2_en = 1'b1; wr2_addr = ADDR_W'(2 * p - 1); wr2_data = 16'h0200 + DATA_W'(2 * p - 1);
      tick();
    end
    wr2_en = 1'b0;
    check("ilv_valid_early", {31'd0, dout_valid}, 32'd0);
    wr1_en = 1'b1; wr1_addr = elem_idx(0, 0); wr1_data = 16'h0200;
    tick();
    wr1_en = 1'b0;
    check("ilv_latency_valid", {31'd0, dout_valid}, 32'd1);
    check("ilv_latency_data", {16'd0, dout_data}, 32'h0200);
    stream_check("ilv", 16'h0200, 15, 16'h0000);

    // Stalling consumer, ready pattern 1,0,0,1.
    fill_seq(16'h0300);
    k = 0; hs = 0; cyc = 0;
    while (k < N_ENTRIES && cyc < 40) begin
      dout_ready = pat[cyc % 4];
      check($sformatf("stall_valid_c%0d", cyc), {31'd0, dout_valid}, 32'd1);
      check($sformatf("stall_data_c%0d", cyc), {16'd0, dout_data}, {16'd0, 16'h0300 + DATA_W'(k)});
      check($sformatf("stall_last_c%0d", cyc), {31'd0, dout_last}, (k == 8) ? 32'd1 : 32'd0);
      if (dout_ready) begin
        k++;
        hs++;
      end
      tick();
      cyc++;
    end
    check("stall_handshakes", hs, 32'd9);
    check("stall_done", {31'd0, done}, 32'd1);
    dout_ready = 1'b0;
    tick();

    // Same-address collision and out-of-range write.
    wr1_en = 1'b1; wr1_addr = elem_idx(1, 1); wr1_data = 16'hAAAA;
    wr2_en = 1'b1; wr2_addr = elem_idx(1, 1); wr2_data = 16'h5555;
    tick();
    wr2_en = 1'b0;
    check("coll_err", {31'd0, err}, 32'd1);
    wr1_addr = 4'd12; wr1_data = 16'hDEAD;
    tick();
    check("oob_err", {31'd0, err}, 32'd1);
    check("oob_valid", {31'd0, dout_valid}, 32'd0);
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i != 4) begin
        wr1_addr = ADDR_W'(i); wr1_data = 16'h0400 + DATA_W'(i);
        tick();
      end
    end
    wr1_en = 1'b0;
    stream_check("coll", 16'h0400, 4, 16'hAAAA);
    check("coll_err_sticky", {31'd0, err}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("coll_err_cleared", {31'd0, err}, 32'd0);

    // Write during stream, then clear mid-stream.
    fill_seq(16'h0500);
    dout_ready = 1'b0;
    wr1_en = 1'b1; wr1_addr = elem_idx(0, 0); wr1_data = 16'hFFFF;
    tick();
    wr1_en = 1'b0;
    check("strwr_valid", {31'd0, dout_valid}, 32'd1);
    check("strwr_data", {16'd0, dout_data}, 32'h0500);
    check("strwr_err", {31'd0, err}, 32'd1);
    dout_ready = 1'b1;
    tick();
    check("strwr_next", {16'd0, dout_data}, 32'h0501);
    dout_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", {31'd0, dout_valid}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_last", {31'd0, dout_last}, 32'd0);
    fill_seq(16'h0600);
    stream_check("postclr", 16'h0600, 15, 16'h0000);

    // Asynchronous reset at element 5 of a stream.
    fill_seq(16'h0700);
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rstmid_pre", {16'd0, dout_data}, 32'h0705);
    #1 reset = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, dout_valid}, 32'd0);
    check("rstmid_data", {16'd0, dout_data}, 32'd0);
    check("rstmid_last", {31'd0, dout_last}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rstmid_idle", {31'd0, dout_valid}, 32'd0);
    fill_seq(16'h0800);
    stream_check("postrst", 16'h0800, 15, 16'h0000);
    check("final_err", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
